// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: holds the PC, addresses the instruction ROM and
// presents PC, instruction and AdEL status to the F/D register.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_BASE    = 32'h0000_3000,
   parameter int unsigned IM_WORDS   = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] I_A,
   input  logic [31:0] I_D,
   output logic [31:0] F_PC,
   output logic [31:0] F_instr,
   output logic [4:0]  F_exc
);

   localparam logic [31:0] IM_LAST = IM_BASE + 32'(IM_WORDS * 4) - 32'd4;
   localparam logic [4:0]  EXC_NONE = 5'd0;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        ad_err;

   always_ff @(posedge clk) begin
      if (reset) pc <= RESET_PC;
      else       pc <= pc_next;
   end

   // CP0 redirects override a stall; a stalled branch is retried by D next cycle.
   always_comb begin
      pc_next = pc + 32'd4;
      if (exc_req)       pc_next = HANDLER_PC;
      else if (eret_req) pc_next = epc;
      else if (stall)    pc_next = pc;
      else if (br_valid) pc_next = br_target;
   end

   always_comb begin
      ad_err = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
   end

   assign I_A     = pc;
   assign F_PC    = pc;
   assign F_instr = ad_err ? '0 : I_D;
   assign F_exc   = ad_err ? EXC_ADEL : EXC_NONE;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed scoreboard bench for ifu_fetch: expected PCs are queued with each
// stimulus step and compared against F_PC/I_A/F_instr/F_exc after the edge.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        reset, stall, br_valid, exc_req, eret_req;
   logic [31:0] br_target, epc;
   logic [31:0] I_A, I_D, F_PC, F_instr;
   logic [4:0]  F_exc;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   ifu_fetch #(
      .RESET_PC  (32'h0000_3000),
      .HANDLER_PC(32'h0000_4180),
      .IM_BASE   (32'h0000_3000),
      .IM_WORDS  (4096)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .br_valid (br_valid),
      .br_target(br_target),
      .exc_req  (exc_req),
      .eret_req (eret_req),
      .epc      (epc),
      .I_A      (I_A),
      .I_D      (I_D),
      .F_PC     (F_PC),
      .F_instr  (F_instr),
      .F_exc    (F_exc)
   );

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h3C01_1234;
      return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
   endfunction

   // Legal window is 0x3000..0x6FFC, word aligned.
   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
   endfunction

   always_comb I_D = rom(I_A);

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Queue the PC expected after the next edge, clock it, then score.
   task automatic step(input string tag, input logic [31:0] exp_pc);
      logic [31:0] e;
      exp_q.push_back(exp_pc);
      @(posedge clk);
      #1;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s_queue: observed empty expected entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check32({tag, "_pc"},    F_PC,    e);
         check32({tag, "_ia"},    I_A,     e);
         check32({tag, "_instr"}, F_instr, bad_addr(e) ? 32'h0 : rom(e));
         check5 ({tag, "_exc"},   F_exc,   bad_addr(e) ? 5'd4 : 5'd0);
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; br_valid = 1'b0; exc_req = 1'b0;
      eret_req = 1'b0; br_target = '0; epc = '0;
      @(negedge clk);
      step("reset", 32'h0000_3000);
      check32("reset_rom_word", F_instr, 32'h3C01_1234);

      reset = 1'b0;
      step("seq1", 32'h0000_3004);
      step("seq2", 32'h0000_3008);

      stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
      step("stall_br1", 32'h0000_3008);
      step("stall_br2", 32'h0000_3008);
      stall = 1'b0;
      step("br_after_stall", 32'h0000_3100);
      br_valid = 1'b0;
      step("seq_after_br", 32'h0000_3104);
      stall = 1'b1;
      step("stall_only", 32'h0000_3104);
      stall = 1'b0;

      br_valid = 1'b1; br_target = 32'h0000_3101;
      step("br_misaligned", 32'h0000_3101);
      br_valid = 1'b0; exc_req = 1'b1;
      step("exc_entry", 32'h0000_4180);
      exc_req = 1'b0;
      step("handler_seq", 32'h0000_4184);

      exc_req = 1'b1; eret_req = 1'b1; stall = 1'b1; br_valid = 1'b1;
      epc = 32'h0000_3200; br_target = 32'h0000_3500;
      step("all_together", 32'h0000_4180);
      exc_req = 1'b0; stall = 1'b0; br_valid = 1'b0;
      step("eret", 32'h0000_3200);
      epc = 32'h0000_3202;
      step("eret_misaligned", 32'h0000_3202);
      eret_req = 1'b0;

      br_valid = 1'b1; br_target = 32'h0000_6FF8;
      step("to_6ff8", 32'h0000_6FF8);
      br_valid = 1'b0;
      step("top_legal", 32'h0000_6FFC);
      step("past_top", 32'h0000_7000);
      br_valid = 1'b1; br_target = 32'h0000_2FFC;
      step("below_base", 32'h0000_2FFC);
      br_target = 32'hFFFF_FFFC;
      step("to_max", 32'hFFFF_FFFC);
      br_valid = 1'b0;
      step("wrap", 32'h0000_0000);

      br_valid = 1'b1; br_target = 32'h0000_3400;
      step("to_3400", 32'h0000_3400);
      reset = 1'b1; exc_req = 1'b1; br_target = 32'h0000_5000;
      step("reset_priority", 32'h0000_3000);
      reset = 1'b0; exc_req = 1'b0; br_valid = 1'b0;
      step("post_reset_seq", 32'h0000_3004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish by 100000");
      $fatal(1, "timeout");
   end

endmodule
